// File: rtl/uart_mm_pkg.sv
// Shared types and constants for the UART-fed matrix-multiply frame controller.
package uart_mm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PAYLOAD   = 2'd1,
        ST_CHECK     = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_CHECKSUM = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_OVERRUN  = 2'd3;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
    localparam int         DEFAULT_N_ELEM    = 32;

endpackage

// File: rtl/uart_rx_event.sv
// Turns the UART receiver's level-style ready into a single-cycle byte event.
module uart_rx_event (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_rx_ready,
    input  logic [7:0] i_rx_data,
    output logic       o_event,
    output logic [7:0] o_byte
);

    logic r_rdy_d;

    // Delayed copy of rx_ready for rising-edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdy_d <= 1'b0;
        end else begin
            r_rdy_d <= i_rx_ready;
        end
    end

    // The byte is stable while ready is high, so it is taken alongside the edge.
    assign o_event = i_rx_ready & ~r_rdy_d;
    assign o_byte  = i_rx_data;

endmodule

// File: rtl/uart_frame_ctrl.sv
// Frame controller: sync byte, N_ELEM payload bytes into the matrix buffer,
// XOR checksum, then hands off to the multiplier and waits for completion.
module uart_frame_ctrl
    import uart_mm_pkg::*;
#(
    parameter int         N_ELEM         = DEFAULT_N_ELEM,
    parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int         TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [7:0]                rx_data,
    input  logic                      rx_ready,
    input  logic                      mm_done,
    output logic                      wr_en,
    output logic [$clog2(N_ELEM)-1:0] wr_addr,
    output logic [7:0]                wr_data,
    output logic                      mm_start,
    output logic                      busy,
    output logic                      frame_ok,
    output logic [1:0]                err_code
);

    localparam int AW = $clog2(N_ELEM);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [AW-1:0] LAST_ELEM = AW'(N_ELEM - 1);
    localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

    logic          w_event;
    logic [7:0]    w_byte;

    state_t        r_state;
    logic [AW-1:0] r_cnt;
    logic [7:0]    r_acc;
    logic [TW-1:0] r_to_cnt;
    logic          r_wr_en;
    logic [AW-1:0] r_wr_addr;
    logic [7:0]    r_wr_data;
    logic          r_mm_start;
    logic          r_frame_ok;
    logic          r_busy;
    logic [1:0]    r_err;

    uart_rx_event u_rx_event (
        .clk        (clk),
        .reset      (reset),
        .i_rx_ready (rx_ready),
        .i_rx_data  (rx_data),
        .o_event    (w_event),
        .o_byte     (w_byte)
    );

    // Frame FSM with all outputs registered; pulses default low every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_acc      <= 8'h00;
            r_to_cnt   <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= 8'h00;
            r_mm_start <= 1'b0;
            r_frame_ok <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= ERR_NONE;
        end else begin
            r_wr_en    <= 1'b0;
            r_mm_start <= 1'b0;
            r_frame_ok <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_event && (w_byte == SYNC_BYTE)) begin
                        r_state  <= ST_PAYLOAD;
                        r_busy   <= 1'b1;
                        r_cnt    <= '0;
                        r_acc    <= 8'h00;
                        r_to_cnt <= '0;
                        r_err    <= ERR_NONE;
                    end
                end
                ST_PAYLOAD: begin
                    if (w_event) begin
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_cnt;
                        r_wr_data <= w_byte;
                        r_acc     <= r_acc ^ w_byte;
                        r_to_cnt  <= '0;
                        if (r_cnt == LAST_ELEM) begin
                            r_state <= ST_CHECK;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end else if (r_to_cnt == TO_LAST) begin
                        r_err   <= ERR_TIMEOUT;
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (w_event) begin
                        r_to_cnt <= '0;
                        if (w_byte == r_acc) begin
                            r_mm_start <= 1'b1;
                            r_frame_ok <= 1'b1;
                            r_state    <= ST_WAIT_DONE;
                        end else begin
                            r_err   <= ERR_CHECKSUM;
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else if (r_to_cnt == TO_LAST) begin
                        r_err   <= ERR_TIMEOUT;
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                ST_WAIT_DONE: begin
                    // A byte arriving while the multiplier runs is dropped and flagged.
                    if (w_event) begin
                        r_err <= ERR_OVERRUN;
                    end
                    if (mm_done) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_data  = r_wr_data;
    assign mm_start = r_mm_start;
    assign frame_ok = r_frame_ok;
    assign busy     = r_busy;
    assign err_code = r_err;

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Self-checking bench: behavioural frame model compared every cycle, plus directed literal checks.
module tb_uart_frame_ctrl;

    localparam int         N  = 32;
    localparam int         T  = 1000;
    localparam logic [7:0] SB = 8'hA5;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_ready = 1'b0;
    logic       mm_done = 1'b0;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       mm_start;
    logic       busy;
    logic       frame_ok;
    logic [1:0] err_code;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;
    bit rand_mode = 1'b0;

    uart_frame_ctrl #(.N_ELEM(N), .SYNC_BYTE(SB), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_ready(rx_ready),
        .mm_done(mm_done), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .mm_start(mm_start), .busy(busy), .frame_ok(frame_ok), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: frame rules expressed as byte counts and flags.
    bit         m_prev = 1'b0, m_in_frame = 1'b0, m_wait = 1'b0;
    int         m_n = 0, m_sil = 0;
    logic [7:0] m_acc = 8'h00;
    logic       e_wr_en = 1'b0, e_mm_start = 1'b0, e_frame_ok = 1'b0, e_busy = 1'b0;
    logic [4:0] e_wr_addr = 5'd0;
    logic [7:0] e_wr_data = 8'h00;
    logic [1:0] e_err = 2'd0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_prev <= 1'b0; m_in_frame <= 1'b0; m_wait <= 1'b0; m_n <= 0; m_sil <= 0;
            m_acc <= 8'h00; e_wr_en <= 1'b0; e_mm_start <= 1'b0; e_frame_ok <= 1'b0;
            e_busy <= 1'b0; e_wr_addr <= 5'd0; e_wr_data <= 8'h00; e_err <= 2'd0;
        end else begin
            m_prev <= rx_ready;
            e_wr_en <= 1'b0; e_mm_start <= 1'b0; e_frame_ok <= 1'b0;
            if (m_wait) begin
                if (rx_ready && !m_prev) e_err <= 2'd3;
                if (mm_done) begin m_wait <= 1'b0; e_busy <= 1'b0; end
            end else if (m_in_frame) begin
                if (rx_ready && !m_prev) begin
                    m_sil <= 0;
                    if (m_n < N) begin
                        e_wr_en <= 1'b1; e_wr_addr <= 5'(m_n); e_wr_data <= rx_data;
                        m_acc <= m_acc ^ rx_data; m_n <= m_n + 1;
                    end else begin
                        m_in_frame <= 1'b0;
                        if (rx_data == m_acc) begin
                            m_wait <= 1'b1; e_mm_start <= 1'b1; e_frame_ok <= 1'b1;
                        end else begin
                            e_err <= 2'd1; e_busy <= 1'b0;
                        end
                    end
                end else if (m_sil + 1 == T) begin
                    e_err <= 2'd2; m_in_frame <= 1'b0; e_busy <= 1'b0;
                end else begin
                    m_sil <= m_sil + 1;
                end
            end else if (rx_ready && !m_prev && rx_data == SB) begin
                m_in_frame <= 1'b1; m_n <= 0; m_acc <= 8'h00; m_sil <= 0;
                e_err <= 2'd0; e_busy <= 1'b1;
            end
        end
    end

    // Write log and pulse counters taken from the DUT for directed checks.
    logic [4:0] wa_q[$];
    logic [7:0] wd_q[$];
    int mm_cnt = 0, ok_cnt = 0;
    logic p_wr = 1'b0, p_mm = 1'b0, p_ok = 1'b0;

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("wr_en", wr_en, e_wr_en);
            if (e_wr_en) begin
                chk("wr_addr", wr_addr, e_wr_addr);
                chk("wr_data", wr_data, e_wr_data);
            end
            chk("mm_start", mm_start, e_mm_start);
            chk("frame_ok", frame_ok, e_frame_ok);
            chk("busy", busy, e_busy);
            chk("err_code", err_code, e_err);
            if (wr_en && p_wr) chk("wr_en_single", 1, 0);
            if (mm_start && p_mm) chk("mm_start_single", 1, 0);
            if (frame_ok && p_ok) chk("frame_ok_single", 1, 0);
            if (wr_en) begin wa_q.push_back(wr_addr); wd_q.push_back(wr_data); end
            if (mm_start) mm_cnt++;
            if (frame_ok) ok_cnt++;
            p_wr = wr_en; p_mm = mm_start; p_ok = frame_ok;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        mm_done = rand_mode ? ($urandom_range(0, 9) == 0) : 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
        tick();
        rx_data = b;
        rx_ready = 1'b1;
        repeat (hold) tick();
        rx_ready = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_frame(input logic [7:0] csum);
        send_byte(SB, 2, 1);
        for (int i = 1; i <= N; i++) send_byte(8'(i), 2, 1);
        send_byte(csum, 2, 1);
    endtask

    task automatic pulse_done();
        tick();
        mm_done = 1'b1;
        tick();
    endtask

    task automatic check_outputs_zero(input string nm);
        chk({nm, "_wr_en"}, wr_en, 0);
        chk({nm, "_wr_addr"}, wr_addr, 0);
        chk({nm, "_wr_data"}, wr_data, 0);
        chk({nm, "_mm_start"}, mm_start, 0);
        chk({nm, "_frame_ok"}, frame_ok, 0);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_err"}, err_code, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, mbase, obase, k, found;
        logic [7:0] frame[$];
        logic [7:0] cs, b;
        #1 reset = 1'b1;
        #1 cmp_en = 1'b1;
        repeat (3) tick();
        check_outputs_zero("reset");
        reset = 1'b0;
        repeat (2) tick();

        // Junk before sync, then a good frame
        base = wa_q.size(); mbase = mm_cnt; obase = ok_cnt;
        send_byte(8'h3C, 1, 2);
        send_byte(8'h7F, 3, 2);
        chk("junk_nwr", wa_q.size() - base, 0);
        chk("junk_busy", busy, 0);
        send_frame(8'h20);
        repeat (3) tick();
        chk("good_nwr", wa_q.size() - base, 32);
        for (int i = 0; i < N; i++) begin
            chk("good_addr", wa_q[base + i], i);
            chk("good_data", wd_q[base + i], i + 1);
        end
        chk("good_mm", mm_cnt - mbase, 1);
        chk("good_ok", ok_cnt - obase, 1);
        chk("good_busy", busy, 1);
        chk("model_busy", e_busy, 1);
        chk("good_err", err_code, 0);
        repeat (5) tick();
        chk("good_busy_hold", busy, 1);
        pulse_done();
        tick();
        chk("good_idle", busy, 0);

        // Bad checksum
        base = wa_q.size(); mbase = mm_cnt;
        send_frame(8'h21);
        repeat (3) tick();
        chk("bad_nwr", wa_q.size() - base, 32);
        chk("bad_mm", mm_cnt - mbase, 0);
        chk("bad_err", err_code, 1);
        chk("model_err", e_err, 1);
        chk("bad_busy", busy, 0);

        // Overrun while waiting for the multiplier
        send_frame(8'h20);
        tick();
        base = wa_q.size();
        send_byte(8'h11, 2, 2);
        chk("ovr_nwr", wa_q.size() - base, 0);
        chk("ovr_err", err_code, 3);
        chk("ovr_busy", busy, 1);
        pulse_done();
        tick();
        chk("ovr_idle", busy, 0);
        chk("ovr_err_hold", err_code, 3);

        // Timeout after 5 payload bytes
        base = wa_q.size();
        send_byte(SB, 2, 1);
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1, 1);
        tick();
        rx_data = 8'h05;
        rx_ready = 1'b1;
        tick();
        found = 0;
        for (k = 1; k <= T + 100; k++) begin
            tick();
            if (err_code == 2'd2) begin found = k; break; end
        end
        chk("to_cycles", found, T);
        chk("to_busy", busy, 0);
        rx_ready = 1'b0;
        repeat (5) tick();
        chk("to_nwr", wa_q.size() - base, 5);

        // Reset mid-frame
        send_byte(SB, 2, 1);
        for (int i = 1; i <= 10; i++) send_byte(8'(i), 2, 1);
        tick();
        #1 reset = 1'b1;
        #1 check_outputs_zero("midrst");
        repeat (2) tick();
        reset = 1'b0;
        base = wa_q.size(); mbase = mm_cnt;
        repeat (3) tick();
        chk("rst_nwr", wa_q.size() - base, 0);
        send_frame(8'h20);
        repeat (2) tick();
        chk("rst_nwr2", wa_q.size() - base, 32);
        chk("rst_addr0", wa_q[base], 0);
        chk("rst_mm", mm_cnt - mbase, 1);
        pulse_done();

        // Randomized frames against the model
        rand_mode = 1'b1;
        for (int f = 0; f < 25; f++) begin
            for (int j = 0; j < $urandom_range(0, 2); j++) begin
                b = 8'($urandom_range(0, 255));
                if (b == SB) b = 8'h00;
                send_byte(b, $urandom_range(1, 3), $urandom_range(0, 3));
            end
            frame.delete();
            cs = 8'h00;
            for (int j = 0; j < N; j++) begin
                b = ($urandom_range(0, 7) == 0) ? SB : 8'($urandom_range(0, 255));
                frame.push_back(b);
                cs ^= b;
            end
            send_byte(SB, $urandom_range(1, 3), $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                k = $urandom_range(0, N);
                for (int j = 0; j < k; j++) send_byte(frame[j], $urandom_range(1, 3), $urandom_range(0, 3));
                repeat (T + 5) tick();
            end else if ($urandom_range(0, 9) == 0) begin
                for (int j = 0; j < 7; j++) send_byte(frame[j], $urandom_range(1, 3), $urandom_range(0, 3));
                #1 reset = 1'b1;
                repeat (2) tick();
                reset = 1'b0;
            end else begin
                for (int j = 0; j < N; j++) send_byte(frame[j], $urandom_range(1, 3), $urandom_range(0, 3));
                if ($urandom_range(0, 3) == 0) cs = cs ^ 8'h5A;
                send_byte(cs, $urandom_range(1, 3), $urandom_range(0, 3));
                if ($urandom_range(0, 2) == 0) send_byte(8'($urandom_range(0, 255)), 1, 2);
            end
            rand_mode = 1'b0;
            pulse_done();
            rand_mode = 1'b1;
            repeat (3) tick();
        end
        rand_mode = 1'b0;
        repeat (4) tick();
        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
